// File: rtl/ins_mem_ctrl.sv
// ins_mem_ctrl: instruction memory with a streaming loader and a pipelined fetch port.
//
// A controller FSM (IDLE -> LOAD -> DONE -> IDLE) writes a block of words from a
// valid/ready stream, starting at a programmable base address and wrapping modulo DEPTH,
// then pulses o_load_done. Outside a load the fetch port accepts one read per cycle with
// a latency of 1 (OUT_REG=0) or 2 (OUT_REG=1) cycles.
//
// Ports:
//   i_clk, i_rst_n      clock (rising edge), asynchronous active-low reset
//   i_load_start        start a load (honoured in IDLE only)
//   i_load_base         first write address, captured at start
//   i_load_len          word count, captured at start, clamped to DEPTH
//   i_load_valid/data   load stream; a word transfers when valid && o_load_ready
//   o_load_ready        high in LOAD
//   o_load_done         high for the single cycle spent in DONE
//   o_busy              high in LOAD and DONE
//   i_rd_req/i_rd_addr  fetch request; accepted when i_rd_req && o_rd_ready
//   o_rd_ready          high in IDLE
//   o_rd_valid/o_rd_data fetched word (zero for out-of-range addresses)
//   o_err               sticky error flag, cleared only by reset
module ins_mem_ctrl #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned OUT_REG    = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load_start,
    input  logic [ADDR_WIDTH-1:0] i_load_base,
    input  logic [ADDR_WIDTH:0]   i_load_len,
    input  logic                  i_load_valid,
    input  logic [WIDTH-1:0]      i_load_data,
    output logic                  o_load_ready,
    output logic                  o_load_done,
    output logic                  o_busy,
    input  logic                  i_rd_req,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic                  o_rd_ready,
    output logic                  o_rd_valid,
    output logic [WIDTH-1:0]      o_rd_data,
    output logic                  o_err
);

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LAST_L  = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e                r_state;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_load_ready;
    logic                  r_load_done;
    logic                  r_busy;
    logic                  r_rd_ready;
    logic                  r_rd_valid;
    logic [WIDTH-1:0]      r_rd_data;
    logic                  r_err;

    logic [WIDTH-1:0]      r_mem [DEPTH];

    logic                  w_xfer;
    logic                  w_rd_acc;
    logic                  w_rd_oob;
    logic                  w_base_oob;
    logic [ADDR_WIDTH:0]   w_base_sub;
    logic [ADDR_WIDTH-1:0] w_base_eff;
    logic [ADDR_WIDTH:0]   w_len_clamp;
    logic [ADDR_WIDTH-1:0] w_ptr_next;
    logic                  w_last;
    logic [WIDTH-1:0]      w_rd_word;

    assign w_xfer      = r_load_ready & i_load_valid;
    assign w_rd_acc    = i_rd_req & r_rd_ready;
    assign w_rd_oob    = ({1'b0, i_rd_addr} >= DEPTH_L);
    assign w_base_oob  = ({1'b0, i_load_base} >= DEPTH_L);
    // An out-of-range base wraps once; any base fits after a single subtraction.
    assign w_base_sub  = {1'b0, i_load_base} - DEPTH_L;
    assign w_base_eff  = w_base_oob ? w_base_sub[ADDR_WIDTH-1:0] : i_load_base;
    assign w_len_clamp = (i_load_len > DEPTH_L) ? DEPTH_L : i_load_len;
    assign w_ptr_next  = ({1'b0, r_wr_ptr} == LAST_L) ? '0 : r_wr_ptr + 1'b1;
    assign w_last      = (r_count == r_len - 1'b1);
    assign w_rd_word   = w_rd_oob ? '0 : r_mem[i_rd_addr];

    // Memory array has no reset; contents survive an aborted load.
    always_ff @(posedge i_clk) begin
        if (w_xfer) begin
            r_mem[r_wr_ptr] <= i_load_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_wr_ptr     <= '0;
            r_len        <= '0;
            r_count      <= '0;
            r_load_ready <= 1'b0;
            r_load_done  <= 1'b0;
            r_busy       <= 1'b0;
            r_rd_ready   <= 1'b1;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
            r_err        <= 1'b0;
        end else begin
            // Fetch stage 1: reads are only accepted in IDLE, so they never
            // collide with a write on the same edge.
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data <= w_rd_word;
                if (w_rd_oob) begin
                    r_err <= 1'b1;
                end
            end

            unique case (r_state)
                StIdle: begin
                    if (i_load_start) begin
                        r_wr_ptr   <= w_base_eff;
                        r_len      <= w_len_clamp;
                        r_count    <= '0;
                        r_busy     <= 1'b1;
                        r_rd_ready <= 1'b0;
                        if (w_base_oob) begin
                            r_err <= 1'b1;
                        end
                        if (w_len_clamp == '0) begin
                            r_state     <= StDone;
                            r_load_done <= 1'b1;
                        end else begin
                            r_state      <= StLoad;
                            r_load_ready <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    if (i_load_start) begin
                        r_err <= 1'b1;
                    end
                    if (w_xfer) begin
                        r_wr_ptr <= w_ptr_next;
                        r_count  <= r_count + 1'b1;
                        if (w_last) begin
                            r_state      <= StDone;
                            r_load_ready <= 1'b0;
                            r_load_done  <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (i_load_start) begin
                        r_err <= 1'b1;
                    end
                    r_state     <= StIdle;
                    r_load_done <= 1'b0;
                    r_busy      <= 1'b0;
                    r_rd_ready  <= 1'b1;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Optional second fetch stage; it only loads on valid so rd_data holds between reads.
    if (OUT_REG != 0) begin : g_out_reg
        logic             r_out_valid;
        logic [WIDTH-1:0] r_out_data;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_out_valid <= 1'b0;
                r_out_data  <= '0;
            end else begin
                r_out_valid <= r_rd_valid;
                if (r_rd_valid) begin
                    r_out_data <= r_rd_data;
                end
            end
        end

        assign o_rd_valid = r_out_valid;
        assign o_rd_data  = r_out_data;
    end else begin : g_no_out_reg
        assign o_rd_valid = r_rd_valid;
        assign o_rd_data  = r_rd_data;
    end

    assign o_load_ready = r_load_ready;
    assign o_load_done  = r_load_done;
    assign o_busy       = r_busy;
    assign o_rd_ready   = r_rd_ready;
    assign o_err        = r_err;

endmodule

// File: tb/tb_ins_mem_ctrl.sv
// Directed bench for ins_mem_ctrl: instance a (DEPTH=256, OUT_REG=0) and
// instance b (DEPTH=200, OUT_REG=1) share one clock.
module tb_ins_mem_ctrl;

    logic       clk = 1'b0;
    int         total = 0;
    int         bad = 0;

    // Instance a: DEPTH=256, OUT_REG=0
    logic       a_rst_n, a_load_start, a_load_valid, a_rd_req;
    logic [7:0] a_load_base, a_load_data, a_rd_addr;
    logic [8:0] a_load_len;
    logic       a_load_ready, a_load_done, a_busy, a_rd_ready, a_rd_valid, a_err;
    logic [7:0] a_rd_data;

    // Instance b: DEPTH=200, OUT_REG=1
    logic       b_rst_n, b_load_start, b_load_valid, b_rd_req;
    logic [7:0] b_load_base, b_load_data, b_rd_addr;
    logic [8:0] b_load_len;
    logic       b_load_ready, b_load_done, b_busy, b_rd_ready, b_rd_valid, b_err;
    logic [7:0] b_rd_data;

    ins_mem_ctrl #(.WIDTH(8), .DEPTH(256), .OUT_REG(0)) dut_a (
        .i_clk(clk), .i_rst_n(a_rst_n), .i_load_start(a_load_start),
        .i_load_base(a_load_base), .i_load_len(a_load_len), .i_load_valid(a_load_valid),
        .i_load_data(a_load_data), .o_load_ready(a_load_ready), .o_load_done(a_load_done),
        .o_busy(a_busy), .i_rd_req(a_rd_req), .i_rd_addr(a_rd_addr),
        .o_rd_ready(a_rd_ready), .o_rd_valid(a_rd_valid), .o_rd_data(a_rd_data),
        .o_err(a_err)
    );

    ins_mem_ctrl #(.WIDTH(8), .DEPTH(200), .OUT_REG(1)) dut_b (
        .i_clk(clk), .i_rst_n(b_rst_n), .i_load_start(b_load_start),
        .i_load_base(b_load_base), .i_load_len(b_load_len), .i_load_valid(b_load_valid),
        .i_load_data(b_load_data), .o_load_ready(b_load_ready), .o_load_done(b_load_done),
        .o_busy(b_busy), .i_rd_req(b_rd_req), .i_rd_addr(b_rd_addr),
        .o_rd_ready(b_rd_ready), .o_rd_valid(b_rd_valid), .o_rd_data(b_rd_data),
        .o_err(b_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_start(input logic [7:0] base, input logic [8:0] len);
        a_load_start = 1'b1;
        a_load_base  = base;
        a_load_len   = len;
        tick();
        a_load_start = 1'b0;
    endtask

    task automatic a_xfer(input logic [7:0] data);
        a_load_valid = 1'b1;
        a_load_data  = data;
        tick();
        a_load_valid = 1'b0;
    endtask

    task automatic a_read(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        a_rd_req  = 1'b1;
        a_rd_addr = addr;
        tick();
        a_rd_req  = 1'b0;
        chk({tag, "_valid"}, a_rd_valid, 1);
        chk({tag, "_data"}, a_rd_data, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_rst_n = 0; a_load_start = 0; a_load_valid = 0; a_rd_req = 0;
        a_load_base = 0; a_load_data = 0; a_rd_addr = 0; a_load_len = 0;
        b_rst_n = 0; b_load_start = 0; b_load_valid = 0; b_rd_req = 0;
        b_load_base = 0; b_load_data = 0; b_rd_addr = 0; b_load_len = 0;
        tick();
        tick();
        chk("rst_load_ready", a_load_ready, 0);
        chk("rst_load_done", a_load_done, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_err", a_err, 0);
        chk("rst_rd_valid", a_rd_valid, 0);
        chk("rst_rd_data", a_rd_data, 0);
        chk("rst_rd_ready", a_rd_ready, 1);
        chk("rst_b_rd_valid", b_rd_valid, 0);
        a_rst_n = 1;
        b_rst_n = 1;
        tick();

        // Basic load of 4 words with continuous valid
        a_start(8'd0, 9'd4);
        chk("ld_ready", a_load_ready, 1);
        chk("ld_busy", a_busy, 1);
        chk("ld_rd_ready", a_rd_ready, 0);
        a_xfer(8'h11);
        a_xfer(8'h22);
        a_xfer(8'h33);
        chk("ld_done_early", a_load_done, 0);
        a_xfer(8'h44);
        chk("ld_done", a_load_done, 1);
        chk("ld_ready_off", a_load_ready, 0);
        chk("ld_busy_done", a_busy, 1);
        chk("ld_rd_ready_done", a_rd_ready, 0);
        tick();
        chk("ld_done_pulse", a_load_done, 0);
        chk("ld_busy_idle", a_busy, 0);
        chk("ld_rd_ready_back", a_rd_ready, 1);

        // Back-to-back reads 0..3
        a_rd_req = 1'b1;
        a_rd_addr = 8'd0;
        tick();
        chk("b2b_v0", a_rd_valid, 1);
        chk("b2b_d0", a_rd_data, 8'h11);
        a_rd_addr = 8'd1;
        tick();
        chk("b2b_v1", a_rd_valid, 1);
        chk("b2b_d1", a_rd_data, 8'h22);
        a_rd_addr = 8'd2;
        tick();
        chk("b2b_v2", a_rd_valid, 1);
        chk("b2b_d2", a_rd_data, 8'h33);
        a_rd_addr = 8'd3;
        tick();
        a_rd_req = 1'b0;
        chk("b2b_v3", a_rd_valid, 1);
        chk("b2b_d3", a_rd_data, 8'h44);
        tick();
        chk("b2b_idle_valid", a_rd_valid, 0);
        chk("b2b_hold_data", a_rd_data, 8'h44);

        // Read accepted together with load_start sees the pre-load word
        a_rd_req = 1'b1;
        a_rd_addr = 8'd0;
        a_start(8'd0, 9'd1);
        a_rd_req = 1'b0;
        chk("col_rd_valid", a_rd_valid, 1);
        chk("col_rd_old", a_rd_data, 8'h11);
        chk("col_load_ready", a_load_ready, 1);
        chk("col_rd_ready", a_rd_ready, 0);
        a_xfer(8'h55);
        chk("col_done", a_load_done, 1);
        tick();
        a_read("col_new", 8'd0, 8'h55);

        // Wrap around the top of memory
        a_start(8'd254, 9'd4);
        a_xfer(8'hA0);
        a_xfer(8'hA1);
        a_xfer(8'hA2);
        a_xfer(8'hA3);
        chk("wrap_done", a_load_done, 1);
        tick();
        a_read("wrap_254", 8'd254, 8'hA0);
        a_read("wrap_255", 8'd255, 8'hA1);
        a_read("wrap_0", 8'd0, 8'hA2);
        a_read("wrap_1", 8'd1, 8'hA3);
        a_read("wrap_2", 8'd2, 8'h33);
        chk("wrap_err", a_err, 0);

        // Stalled stream: valid 1,0,0,1,0,0,1
        a_start(8'd10, 9'd3);
        a_xfer(8'hB0);
        a_load_data = 8'hFF;
        tick();
        tick();
        chk("stall_ready", a_load_ready, 1);
        a_xfer(8'hB1);
        a_load_data = 8'hEE;
        tick();
        tick();
        chk("stall_no_done", a_load_done, 0);
        a_xfer(8'hB2);
        chk("stall_done", a_load_done, 1);
        tick();
        a_read("stall_10", 8'd10, 8'hB0);
        a_read("stall_11", 8'd11, 8'hB1);
        a_read("stall_12", 8'd12, 8'hB2);

        // Length clamp: 300 requested, exactly 256 transfers
        a_start(8'd0, 9'd300);
        for (int i = 0; i < 256; i++) begin
            a_xfer(8'(i) ^ 8'h5A);
            if (i == 254) chk("clamp_not_done", a_load_done, 0);
        end
        chk("clamp_done", a_load_done, 1);
        tick();
        a_read("clamp_0", 8'd0, 8'h5A);
        a_read("clamp_1", 8'd1, 8'h5B);
        a_read("clamp_255", 8'd255, 8'hA5);

        // load_start during LOAD is ignored but flags an error
        a_start(8'd20, 9'd2);
        a_load_start = 1'b1;
        tick();
        a_load_start = 1'b0;
        chk("restart_err", a_err, 1);
        chk("restart_ready", a_load_ready, 1);
        a_xfer(8'hE0);
        a_xfer(8'hE1);
        chk("restart_done", a_load_done, 1);
        tick();
        a_read("restart_20", 8'd20, 8'hE0);

        // Reset after 2 of 4 words
        a_start(8'd0, 9'd4);
        a_xfer(8'hC0);
        a_xfer(8'hC1);
        a_rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", a_load_ready, 0);
        chk("mid_rst_busy", a_busy, 0);
        chk("mid_rst_err", a_err, 0);
        chk("mid_rst_done", a_load_done, 0);
        chk("mid_rst_rd_ready", a_rd_ready, 1);
        chk("mid_rst_rd_data", a_rd_data, 0);
        #1;
        a_rst_n = 1'b1;
        tick();
        chk("mid_rst_no_done", a_load_done, 0);
        a_read("mid_rst_0", 8'd0, 8'hC0);
        a_read("mid_rst_1", 8'd1, 8'hC1);
        a_read("mid_rst_2", 8'd2, 8'h58);

        // Instance b: base >= DEPTH wraps once and sets err
        chk("b_err_init", b_err, 0);
        b_load_start = 1'b1;
        b_load_base = 8'd205;
        b_load_len = 9'd1;
        tick();
        b_load_start = 1'b0;
        chk("b_base_err", b_err, 1);
        b_load_valid = 1'b1;
        b_load_data = 8'h99;
        tick();
        b_load_valid = 1'b0;
        chk("b_done", b_load_done, 1);
        tick();
        b_rst_n = 1'b0;
        #2;
        b_rst_n = 1'b1;
        chk("b_err_cleared", b_err, 0);
        tick();

        // OUT_REG=1 latency: accept at edge t, valid after edge t+1
        b_rd_req = 1'b1;
        b_rd_addr = 8'd5;
        tick();
        b_rd_req = 1'b0;
        chk("b_lat_t1_valid", b_rd_valid, 0);
        tick();
        chk("b_lat_t2_valid", b_rd_valid, 1);
        chk("b_lat_t2_data", b_rd_data, 8'h99);
        tick();
        chk("b_lat_after", b_rd_valid, 0);
        chk("b_lat_hold", b_rd_data, 8'h99);

        // Out-of-range fetch returns zero and sets err
        b_rd_req = 1'b1;
        b_rd_addr = 8'd210;
        tick();
        b_rd_req = 1'b0;
        chk("b_oob_err", b_err, 1);
        tick();
        chk("b_oob_valid", b_rd_valid, 1);
        chk("b_oob_data", b_rd_data, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
